// File: rtl/mem_lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_lsu_pkg
//  Description : Shared definitions for the load/store memory stage: RV32I
//                opcode and funct3 codes, FSM state encodings, the context
//                latched at issue, and small decode helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_lsu_pkg;

    // Major opcodes
    localparam logic [6:0] INST_TYPE_L = 7'b0000011;
    localparam logic [6:0] INST_TYPE_S = 7'b0100011;

    // Load funct3 codes
    localparam logic [2:0] INST_LB  = 3'b000;
    localparam logic [2:0] INST_LH  = 3'b001;
    localparam logic [2:0] INST_LW  = 3'b010;
    localparam logic [2:0] INST_LBU = 3'b100;
    localparam logic [2:0] INST_LHU = 3'b101;

    // Store funct3 codes
    localparam logic [2:0] INST_SB  = 3'b000;
    localparam logic [2:0] INST_SH  = 3'b001;
    localparam logic [2:0] INST_SW  = 3'b010;

    // FSM state encodings
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    // Instruction context captured when an access is issued, so that the
    // ex_mem inputs may change afterwards without corrupting the access.
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] instaddr;
        logic        regs_wen;
        logic [4:0]  rd_addr;
        logic [1:0]  ofs;
        logic        is_load;
    } lsu_ctx_t;

    // funct3[1:0] encodes the access size: 00 byte, 01 half, 1x word.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   is_misaligned = 1'b0;
            2'b01:   is_misaligned = a[0];
            default: is_misaligned = (a != 2'b00);
        endcase
    endfunction

    // Byte offset actually used for lane selection: the low address bits a
    // naturally aligned access cannot have are dropped.
    function automatic logic [1:0] eff_offset(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   eff_offset = a;
            2'b01:   eff_offset = {a[1], 1'b0};
            default: eff_offset = 2'b00;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lsu_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_lsu_if
//  Description : Data-memory req/gnt/rvalid bus.
//                master (LSU): drives req, we, addr, be, wdata;
//                              receives gnt, rvalid, rdata.
//                slave (memory): the reverse.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_lsu_if #(
    parameter int ADDR_W = 32
) ();
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic              gnt;
    logic              rvalid;
    logic [31:0]       rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output gnt, rvalid, rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_lsu_align.sv
`default_nettype none
// ============================================================================
//  Module      : mem_lsu_align
//  Description : Combinational byte-lane aligner for RV32I loads/stores.
//                i_funct3, i_ofs      : access type and byte offset
//                i_store_data         : store data (rs2)
//                i_rdata              : raw read word from memory
//                o_be, o_wdata        : store byte enables and lane data
//                o_load_data          : shifted, sign/zero-extended load
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_lsu_align
    import mem_lsu_pkg::*;
(
    input  wire logic [2:0]  i_funct3,
    input  wire logic [1:0]  i_ofs,
    input  wire logic [31:0] i_store_data,
    input  wire logic [31:0] i_rdata,
    output logic      [3:0]  o_be,
    output logic      [31:0] o_wdata,
    output logic      [31:0] o_load_data
);
    logic [31:0] w_shifted;

    assign w_shifted = i_rdata >> {i_ofs, 3'b000};

    always_comb begin
        case (i_funct3)
            INST_LB:  o_load_data = {{24{w_shifted[7]}},  w_shifted[7:0]};
            INST_LH:  o_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            INST_LBU: o_load_data = {24'h0, w_shifted[7:0]};
            INST_LHU: o_load_data = {16'h0, w_shifted[15:0]};
            default:  o_load_data = w_shifted;
        endcase
    end

    always_comb begin
        case (i_funct3[1:0])
            2'b00: begin
                o_be    = 4'b0001 << i_ofs;
                o_wdata = {4{i_store_data[7:0]}};
            end
            2'b01: begin
                o_be    = i_ofs[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_store_data[15:0]}};
            end
            default: begin
                o_be    = 4'b1111;
                o_wdata = i_store_data;
            end
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : mem_lsu
//  Description : Load/store memory stage between ex_mem and mem_wb. Issues
//                RV32I loads/stores over a req/gnt/rvalid bus, formats load
//                lanes, stalls the pipeline while an access is outstanding
//                and flags misaligned accesses. Other instructions pass
//                through combinationally.
//  Ports       : clk, rst                      clock, sync active-high reset
//                valid_i, flush_i, inst_i, instaddr_i, regs_wen_i,
//                rd_addr_i, rd_data_i, rs2_data_i   from ex_mem
//                dmem (mem_lsu_if.master)      data-memory bus
//                valid_o, inst_o, instaddr_o, regs_wen_o, rd_addr_o,
//                rd_data_o                     to mem_wb
//                stall_o                       freeze IF..EX and ex_mem
//                misalign_o                    misaligned-access pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter bit MISALIGN_TRAP = 1'b1
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        valid_i,
    input  wire logic        flush_i,
    input  wire logic [31:0] inst_i,
    input  wire logic [31:0] instaddr_i,
    input  wire logic        regs_wen_i,
    input  wire logic [4:0]  rd_addr_i,
    input  wire logic [31:0] rd_data_i,
    input  wire logic [31:0] rs2_data_i,
    mem_lsu_if.master        dmem,
    output logic             valid_o,
    output logic      [31:0] inst_o,
    output logic      [31:0] instaddr_o,
    output logic             regs_wen_o,
    output logic      [4:0]  rd_addr_o,
    output logic      [31:0] rd_data_o,
    output logic             stall_o,
    output logic             misalign_o
);
    logic [2:0]        r_state;
    lsu_ctx_t          r_ctx;
    logic [31:0]       r_load_q;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_be;
    logic [31:0]       r_wdata;

    logic              w_is_load;
    logic              w_is_store;
    logic [2:0]        w_f3;
    logic              w_misal;
    logic              w_live;
    logic              w_issue;
    logic              w_trap;
    logic [1:0]        w_ofs_live;
    logic [ADDR_W-1:0] w_addr;
    logic [2:0]        w_f3_sel;
    logic [1:0]        w_ofs_sel;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [31:0]       w_load_fmt;

    assign w_is_load  = (inst_i[6:0] == INST_TYPE_L);
    assign w_is_store = (inst_i[6:0] == INST_TYPE_S);
    assign w_f3       = inst_i[14:12];
    assign w_misal    = MISALIGN_TRAP && is_misaligned(w_f3, rd_data_i[1:0]);
    assign w_live     = valid_i && !flush_i && !rst;
    assign w_issue    = (r_state == S_IDLE) && w_live && (w_is_load || w_is_store) && !w_misal;
    assign w_trap     = (r_state == S_IDLE) && w_live && (w_is_load || w_is_store) && w_misal;
    assign w_ofs_live = eff_offset(w_f3, rd_data_i[1:0]);
    assign w_addr     = {rd_data_i[ADDR_W-1:2], 2'b00};

    // In IDLE the aligner sees the live instruction (issue cycle); in every
    // other state it sees the latched one, so load formatting in WAIT is
    // immune to ex_mem changes.
    assign w_f3_sel  = (r_state == S_IDLE) ? w_f3       : r_ctx.inst[14:12];
    assign w_ofs_sel = (r_state == S_IDLE) ? w_ofs_live : r_ctx.ofs;

    mem_lsu_align u_align (
        .i_funct3     (w_f3_sel),
        .i_ofs        (w_ofs_sel),
        .i_store_data (rs2_data_i),
        .i_rdata      (dmem.rdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_load_data  (w_load_fmt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_ctx    <= '0;
            r_load_q <= 32'h0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_be     <= 4'h0;
            r_wdata  <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_ctx    <= '{inst: inst_i, instaddr: instaddr_i, regs_wen: regs_wen_i,
                                      rd_addr: rd_addr_i, ofs: w_ofs_live, is_load: w_is_load};
                        r_we     <= w_is_store;
                        r_addr   <= w_addr;
                        r_be     <= w_be;
                        r_wdata  <= w_wdata;
                        if (dmem.gnt)
                            r_state <= w_is_load ? S_WAIT : S_DONE;
                        else
                            r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (flush_i)
                        r_state <= S_IDLE;
                    else if (dmem.gnt)
                        r_state <= r_ctx.is_load ? S_WAIT : S_DONE;
                end
                S_WAIT: begin
                    // A flush coinciding with rvalid needs no drain: the
                    // response has already arrived and is simply dropped.
                    if (dmem.rvalid) begin
                        if (flush_i) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_load_q <= w_load_fmt;
                            r_state  <= S_DONE;
                        end
                    end else if (flush_i) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                S_DRAIN: if (dmem.rvalid) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        valid_o     = valid_i && !flush_i;
        inst_o      = inst_i;
        instaddr_o  = instaddr_i;
        regs_wen_o  = regs_wen_i;
        rd_addr_o   = rd_addr_i;
        rd_data_o   = rd_data_i;
        stall_o     = 1'b0;
        misalign_o  = 1'b0;
        dmem.req    = 1'b0;
        dmem.we     = 1'b0;
        dmem.addr   = '0;
        dmem.be     = 4'h0;
        dmem.wdata  = 32'h0;
        case (r_state)
            S_IDLE: begin
                if (w_issue) begin
                    valid_o    = 1'b0;
                    stall_o    = 1'b1;
                    dmem.req   = 1'b1;
                    dmem.we    = w_is_store;
                    dmem.addr  = w_addr;
                    dmem.be    = w_be;
                    dmem.wdata = w_wdata;
                end else if (w_trap) begin
                    valid_o    = 1'b1;
                    regs_wen_o = 1'b0;
                    misalign_o = 1'b1;
                end
            end
            S_REQ: begin
                valid_o    = 1'b0;
                stall_o    = 1'b1;
                dmem.req   = !flush_i;
                dmem.we    = r_we;
                dmem.addr  = r_addr;
                dmem.be    = r_be;
                dmem.wdata = r_wdata;
            end
            S_WAIT, S_DRAIN: begin
                valid_o = 1'b0;
                stall_o = 1'b1;
            end
            S_DONE: begin
                valid_o    = 1'b1;
                inst_o     = r_ctx.inst;
                instaddr_o = r_ctx.instaddr;
                regs_wen_o = r_ctx.regs_wen && r_ctx.is_load;
                rd_addr_o  = r_ctx.rd_addr;
                rd_data_o  = r_load_q;
            end
            default: ;
        endcase
        if (rst) begin
            valid_o    = 1'b0;
            stall_o    = 1'b0;
            misalign_o = 1'b0;
            dmem.req   = 1'b0;
        end
    end
endmodule
`default_nettype wire
